// File: rtl/bomb_pkg.sv
// Shared types and helpers for the bomb engine: FSM state encoding,
// fuse counter width, default grid size and the flat cell-index mapping.
package bomb_pkg;

   localparam int FUSE_W     = 4;
   localparam int GRID_W_DEF = 10;
   localparam int GRID_H_DEF = 10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TICK   = 3'd1,
      BLAST  = 3'd2,
      DAMAGE = 3'd3,
      OVER   = 3'd4
   } state_t;

   // Flat map index of cell (x, y) on a grid that is w cells wide.
   function automatic int cell_idx(input int x, input int y, input int w);
      return w * y + x;
   endfunction

endpackage

// File: rtl/bomb_if.sv
// Bomb placement handshake between the player input logic (master) and
// the bomb engine (slave). ack/nak are single-cycle pulses.
interface bomb_if;

   logic       req;
   logic [3:0] x;
   logic [3:0] y;
   logic       ack;
   logic       nak;

   modport master (output req, x, y, input ack, nak);
   modport slave  (input req, x, y, output ack, nak);

endinterface

// File: rtl/bomb_blast_unit.sv
// Combinational flame generator: every pending cell emits a plus-shaped
// flame of up to BLAST_RADIUS cells per direction. A ray stops before a
// wall or the grid edge, and the wall cell itself stays dark.
module bomb_blast_unit
   import bomb_pkg::*;
#(
   parameter int GRID_W       = GRID_W_DEF,
   parameter int GRID_H       = GRID_H_DEF,
   parameter int BLAST_RADIUS = 2
) (
   input  logic [GRID_W*GRID_H-1:0] pending,
   input  logic [GRID_W*GRID_H-1:0] wall_map,
   output logic [GRID_W*GRID_H-1:0] flame
);

   localparam int N_CELLS = GRID_W * GRID_H;
   localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

   logic             blocked;
   logic             in_grid;
   int               nx;
   int               ny;
   logic [IDX_W-1:0] src;
   logic [IDX_W-1:0] dst;

   // Walk the four rays of each pending cell; bounds are tested before any
   // coordinate is formed so nothing ever wraps.
   always_comb begin
      flame   = '0;
      blocked = 1'b0;
      in_grid = 1'b0;
      nx      = 0;
      ny      = 0;
      src     = '0;
      dst     = '0;
      for (int y = 0; y < GRID_H; y++) begin
         for (int x = 0; x < GRID_W; x++) begin
            src = IDX_W'(cell_idx(x, y, GRID_W));
            if (pending[src]) begin
               flame[src] = 1'b1;
               for (int d = 0; d < 4; d++) begin
                  blocked = 1'b0;
                  for (int r = 1; r <= BLAST_RADIUS; r++) begin
                     case (d)
                        0: begin
                           in_grid = (x + r <= GRID_W - 1);
                           nx      = in_grid ? x + r : x;
                           ny      = y;
                        end
                        1: begin
                           in_grid = (x >= r);
                           nx      = in_grid ? x - r : x;
                           ny      = y;
                        end
                        2: begin
                           in_grid = (y + r <= GRID_H - 1);
                           nx      = x;
                           ny      = in_grid ? y + r : y;
                        end
                        default: begin
                           in_grid = (y >= r);
                           nx      = x;
                           ny      = in_grid ? y - r : y;
                        end
                     endcase
                     dst = in_grid ? IDX_W'(cell_idx(nx, ny, GRID_W)) : '0;
                     if (!blocked) begin
                        if (!in_grid || wall_map[dst]) begin
                           blocked = 1'b1;
                        end else begin
                           flame[dst] = 1'b1;
                        end
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/bomb_engine.sv
// Bomb map updater: placement handshake, per-cell fuse counters, chained
// wall-blocked blasts and saturating player damage.
//
// state  | meaning
// IDLE   | accept placements, wait for bombTick
// TICK   | clear flames, fuse==1 bombs go pending, others count down
// BLAST  | one chain generation per cycle until nothing new is pending
// DAMAGE | flamed alive players lose one health point
// OVER   | at most one player alive; everything frozen until reset
module bomb_engine
   import bomb_pkg::*;
#(
   parameter int GRID_W       = GRID_W_DEF,
   parameter int GRID_H       = GRID_H_DEF,
   parameter int FUSE_TICKS   = 3,
   parameter int BLAST_RADIUS = 2,
   parameter int NUM_PLAYERS  = 2,
   parameter int HEALTH_W     = 2,
   parameter int HEALTH_INIT  = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            bombTick,
   input  logic [GRID_W*GRID_H-1:0]        wall_map,
   input  logic [NUM_PLAYERS*4-1:0]        player_x,
   input  logic [NUM_PLAYERS*4-1:0]        player_y,
   bomb_if.slave                           place,
   output logic [GRID_W*GRID_H-1:0]        bomb_map,
   output logic [GRID_W*GRID_H-1:0]        flame_map,
   output logic [NUM_PLAYERS*HEALTH_W-1:0] health,
   output logic [NUM_PLAYERS-1:0]          alive,
   output logic                            game_over,
   output logic                            tick_lost
);

   localparam int N_CELLS = GRID_W * GRID_H;
   localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
   localparam logic [NUM_PLAYERS*HEALTH_W-1:0] HEALTH_RST =
      {NUM_PLAYERS{HEALTH_W'(HEALTH_INIT)}};

   state_t                          state;
   logic [N_CELLS-1:0]              pending;
   logic [N_CELLS-1:0]              blast_flame;
   logic [N_CELLS-1:0]              chain_next;
   logic [N_CELLS-1:0]              fuse_one;
   logic [IDX_W-1:0]                place_idx;
   logic                            place_ok;
   logic                            place_accept;
   logic [NUM_PLAYERS*HEALTH_W-1:0] hp_next;
   logic [NUM_PLAYERS-1:0]          alive_next;

   bomb_blast_unit #(
      .GRID_W       (GRID_W),
      .GRID_H       (GRID_H),
      .BLAST_RADIUS (BLAST_RADIUS)
   ) u_blast (
      .pending  (pending),
      .wall_map (wall_map),
      .flame    (blast_flame)
   );

   // Placement legality: inside the playable area, not a wall, not occupied.
   // A tick in the same cycle takes priority over the placement.
   always_comb begin
      place_idx    = IDX_W'(cell_idx(int'(place.x), int'(place.y), GRID_W));
      place_ok     = (int'(place.x) >= 1) && (int'(place.x) <= GRID_W - 2) &&
                     (int'(place.y) >= 1) && (int'(place.y) <= GRID_H - 2) &&
                     !wall_map[place_idx] && !bomb_map[place_idx];
      place_accept = (state == IDLE) && !bombTick && place.req && place_ok;
   end

   // Armed bombs caught by this generation's flame, excluding the ones going off now.
   assign chain_next = bomb_map & ~pending & blast_flame;

   for (genvar c = 0; c < N_CELLS; c++) begin : g_cell
      logic [FUSE_W-1:0] fuse;

      assign fuse_one[c] = (fuse == FUSE_W'(1));

      // Per-cell fuse: loaded on placement, counts down per tick, cleared on detonation.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            fuse <= '0;
         end else if (place_accept && (place_idx == IDX_W'(c))) begin
            fuse <= FUSE_W'(FUSE_TICKS);
         end else if ((state == TICK) && bomb_map[c] && !fuse_one[c]) begin
            fuse <= fuse - FUSE_W'(1);
         end else if ((state == BLAST) && pending[c]) begin
            fuse <= '0;
         end
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      logic [3:0]          px;
      logic [3:0]          py;
      logic [HEALTH_W-1:0] hp;
      logic [IDX_W-1:0]    pidx;
      logic                hit;

      assign px   = player_x[p*4 +: 4];
      assign py   = player_y[p*4 +: 4];
      assign hp   = health[p*HEALTH_W +: HEALTH_W];
      assign pidx = IDX_W'(cell_idx(int'(px), int'(py), GRID_W));
      assign hit  = (int'(px) < GRID_W) && (int'(py) < GRID_H) && flame_map[pidx];

      // One point per tick no matter how many blasts overlap the player; floor at 0.
      assign hp_next[p*HEALTH_W +: HEALTH_W] =
         (alive[p] && hit && (hp != '0)) ? hp - HEALTH_W'(1) : hp;
      assign alive_next[p] = (hp_next[p*HEALTH_W +: HEALTH_W] != '0);
   end

   // Sequencer FSM with registered maps, health and handshake pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bomb_map  <= '0;
         flame_map <= '0;
         pending   <= '0;
         health    <= HEALTH_RST;
         alive     <= '1;
         game_over <= 1'b0;
         place.ack <= 1'b0;
         place.nak <= 1'b0;
         tick_lost <= 1'b0;
      end else begin
         place.ack <= 1'b0;
         place.nak <= 1'b0;
         tick_lost <= 1'b0;
         if (place_accept) begin
            place.ack           <= 1'b1;
            bomb_map[place_idx] <= 1'b1;
         end else if (place.req) begin
            place.nak <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (bombTick) state <= TICK;
            end
            TICK: begin
               flame_map <= '0;
               pending   <= bomb_map & fuse_one;
               tick_lost <= bombTick;
               state     <= BLAST;
            end
            BLAST: begin
               bomb_map  <= bomb_map & ~pending;
               flame_map <= flame_map | blast_flame;
               pending   <= chain_next;
               tick_lost <= bombTick;
               if (chain_next == '0) state <= DAMAGE;
            end
            DAMAGE: begin
               health    <= hp_next;
               alive     <= alive_next;
               tick_lost <= bombTick;
               if ($countones(alive_next) < 2) begin
                  game_over <= 1'b1;
                  state     <= OVER;
               end else begin
                  state <= IDLE;
               end
            end
            OVER: begin
               game_over <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bomb_engine.sv
// Directed scoreboard bench for bomb_engine on the default 10x10 grid.
module tb_bomb_engine;

   localparam int NC = 100;

   typedef struct {
      string        tag;
      logic [127:0] val;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          bomb_tick;
   logic [NC-1:0] wall_map;
   logic [NC-1:0] walls;
   logic [7:0]    player_x;
   logic [7:0]    player_y;
   logic [NC-1:0] bomb_map;
   logic [NC-1:0] flame_map;
   logic [3:0]    health;
   logic [1:0]    alive;
   logic          game_over;
   logic          tick_lost;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   bomb_if place_bus();

   bomb_engine #(
      .GRID_W       (10),
      .GRID_H       (10),
      .FUSE_TICKS   (3),
      .BLAST_RADIUS (2),
      .NUM_PLAYERS  (2),
      .HEALTH_W     (2),
      .HEALTH_INIT  (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bombTick  (bomb_tick),
      .wall_map  (wall_map),
      .player_x  (player_x),
      .player_y  (player_y),
      .place     (place_bus),
      .bomb_map  (bomb_map),
      .flame_map (flame_map),
      .health    (health),
      .alive     (alive),
      .game_over (game_over),
      .tick_lost (tick_lost)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] cm(input int x, input int y);
      logic [127:0] m;
      m = '0;
      m[y*10 + x] = 1'b1;
      return m;
   endfunction

   function automatic logic [127:0] cross33();
      return cm(1,3) | cm(2,3) | cm(3,3) | cm(4,3) | cm(5,3) |
             cm(3,1) | cm(3,2) | cm(3,4) | cm(3,5);
   endfunction

   function automatic logic [127:0] gen22();
      return cm(2,2) | cm(1,2) | cm(3,2) | cm(4,2) | cm(2,1) | cm(2,3) | cm(2,4);
   endfunction

   function automatic logic [127:0] gen42();
      return cm(4,2) | cm(5,2) | cm(6,2) | cm(3,2) | cm(2,2) | cm(4,1) | cm(4,3) | cm(4,4);
   endfunction

   task automatic push(input string tag, input logic [127:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [127:0] obs);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL sb_empty observed=%0h required=<nothing queued>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_players(input logic [3:0] x0, input logic [3:0] y0,
                              input logic [3:0] x1, input logic [3:0] y1);
      player_x = {x1, x0};
      player_y = {y1, y0};
   endtask

   task automatic place_chk(input string tag, input logic [3:0] x, input logic [3:0] y,
                            input logic [1:0] an_exp, input logic [127:0] map_exp);
      push({tag, "_acknak"}, 128'(an_exp));
      push({tag, "_map"}, map_exp);
      place_bus.req = 1'b1;
      place_bus.x   = x;
      place_bus.y   = y;
      step();
      place_bus.req = 1'b0;
      check(128'({place_bus.ack, place_bus.nak}));
      check(128'(bomb_map));
   endtask

   // bombTick sampled by IDLE; returns with the FSM in TICK
   task automatic tick_start();
      bomb_tick = 1'b1;
      step();
      bomb_tick = 1'b0;
   endtask

   task automatic full_tick();
      tick_start();
      repeat (3) step();
   endtask

   task automatic reset_checks(input string tag);
      push({tag, "_bomb"}, '0);
      push({tag, "_flame"}, '0);
      push({tag, "_health"}, 128'(4'hF));
      push({tag, "_flags"}, 128'(6'b110000));
      check(128'(bomb_map));
      check(128'(flame_map));
      check(128'(health));
      check(128'({alive, game_over, place_bus.ack, place_bus.nak, tick_lost}));
   endtask

   initial begin
      walls = '0;
      for (int y = 0; y < 10; y++)
         for (int x = 0; x < 10; x++)
            if (x == 0 || x == 9 || y == 0 || y == 9) walls[y*10 + x] = 1'b1;
      wall_map      = walls;
      bomb_tick     = 1'b0;
      place_bus.req = 1'b0;
      place_bus.x   = '0;
      place_bus.y   = '0;
      set_players(4'd8, 4'd8, 4'd1, 4'd8);
      rst_n = 1'b0;
      repeat (2) step();
      reset_checks("reset");
      rst_n = 1'b1;
      step();

      // single bomb, open field
      place_chk("place33", 4'd3, 4'd3, 2'b10, cm(3,3));
      full_tick();
      full_tick();
      push("fuse_pending_bomb", cm(3,3));
      push("fuse_pending_flame", '0);
      check(128'(bomb_map));
      check(128'(flame_map));
      tick_start();
      push("nak_in_tick", 128'(2'b01));
      place_bus.req = 1'b1;
      place_bus.x   = 4'd5;
      place_bus.y   = 4'd5;
      step();
      place_bus.req = 1'b0;
      check(128'({place_bus.ack, place_bus.nak}));
      push("blast33_flame", cross33());
      push("blast33_bomb", '0);
      step();
      check(128'(flame_map));
      check(128'(bomb_map));
      push("blast33_health", 128'(4'hF));
      step();
      check(128'(health));
      push("flame_persist", cross33());
      step();
      check(128'(flame_map));

      // wall-blocked ray and rejected placements
      walls[3*10 + 4] = 1'b1;
      wall_map = walls;
      place_chk("wall_place33", 4'd3, 4'd3, 2'b10, cm(3,3));
      place_chk("nak_wall", 4'd4, 4'd3, 2'b01, cm(3,3));
      place_chk("nak_border", 4'd0, 4'd5, 2'b01, cm(3,3));
      place_chk("nak_occupied", 4'd3, 4'd3, 2'b01, cm(3,3));
      place_chk("nak_range", 4'd15, 4'd3, 2'b01, cm(3,3));
      full_tick();
      full_tick();
      tick_start();
      step();
      push("lost_in_blast", 128'(3'b011));
      push("wall_flame", cm(1,3) | cm(2,3) | cm(3,3) | cm(3,1) | cm(3,2) | cm(3,4) | cm(3,5));
      bomb_tick     = 1'b1;
      place_bus.req = 1'b1;
      place_bus.x   = 4'd6;
      place_bus.y   = 4'd6;
      step();
      bomb_tick     = 1'b0;
      place_bus.req = 1'b0;
      check(128'({place_bus.ack, place_bus.nak, tick_lost}));
      check(128'(flame_map));
      push("lost_pulse_end", 128'(1'b0));
      step();
      check(128'(tick_lost));
      walls[3*10 + 4] = 1'b0;
      wall_map = walls;

      // chain: (4,2) placed one tick later, both go off on the same tick
      place_chk("chain_a", 4'd2, 4'd2, 2'b10, cm(2,2));
      full_tick();
      place_chk("chain_b", 4'd4, 4'd2, 2'b10, cm(2,2) | cm(4,2));
      full_tick();
      set_players(4'd3, 4'd2, 4'd1, 4'd8);
      tick_start();
      step();
      push("chain_gen1_flame", gen22());
      push("chain_gen1_bomb", cm(4,2));
      step();
      check(128'(flame_map));
      check(128'(bomb_map));
      push("chain_gen2_flame", gen22() | gen42());
      push("chain_gen2_bomb", '0);
      push("chain_gen2_health", 128'(4'hF));
      step();
      check(128'(flame_map));
      check(128'(bomb_map));
      check(128'(health));
      push("overlap_health", 128'(4'b1110));
      push("overlap_alive", 128'(3'b110));
      step();
      check(128'(health));
      check(128'({alive, game_over}));

      // drain player 0 to zero -> game over
      set_players(4'd3, 4'd3, 4'd1, 4'd8);
      place_chk("kill1_place", 4'd3, 4'd3, 2'b10, cm(3,3));
      full_tick();
      full_tick();
      full_tick();
      push("kill1_health", 128'(4'b1101));
      check(128'(health));
      place_chk("kill2_place", 4'd3, 4'd3, 2'b10, cm(3,3));
      full_tick();
      full_tick();
      full_tick();
      push("kill2_health", 128'(4'b1100));
      push("kill2_alive_over", 128'(3'b101));
      check(128'(health));
      check(128'({alive, game_over}));
      push("over_tick_ignored", 128'(1'b0));
      tick_start();
      check(128'(tick_lost));
      step();
      place_chk("over_nak", 4'd5, 4'd5, 2'b01, '0);
      push("over_flame_frozen", cross33());
      push("over_sticky", 128'(3'b101));
      check(128'(flame_map));
      check(128'({alive, game_over}));

      // reset in the middle of a chained blast
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      set_players(4'd3, 4'd2, 4'd1, 4'd8);
      place_chk("rst_chain_a", 4'd2, 4'd2, 2'b10, cm(2,2));
      full_tick();
      place_chk("rst_chain_b", 4'd4, 4'd2, 2'b10, cm(2,2) | cm(4,2));
      full_tick();
      tick_start();
      step();
      push("pre_rst_flame", gen22());
      step();
      check(128'(flame_map));
      rst_n = 1'b0;
      #1;
      reset_checks("mid_blast_rst");
      step();
      rst_n = 1'b1;
      repeat (3) step();
      push("post_rst_health", 128'(4'hF));
      check(128'(health));
      place_chk("post_rst_place", 4'd5, 4'd5, 2'b10, cm(5,5));

      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL sb_leftover observed=%0d required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
